// File: rtl/spi_master_engine.sv
// SPI master engine: one start/data handshake in, SCLK/MOSI/SS_N out.
// A single down-counter times each SCLK half-period. The FSM sequence is
// IDLE -> LEAD -> XFER -> LAG -> IDLE.
//
// Ports:
//   I_CLK, I_RESETN   clock and asynchronous active-low reset
//   I_START           transfer request, sampled in IDLE only
//   I_TX_DATA         word to send, latched on accept
//   I_SS_SEL          target slave index, latched on accept
//   I_CPOL, I_CPHA    SPI mode, latched on accept
//   O_BUSY            high while a transfer is in flight
//   O_DONE            one-cycle end-of-transfer pulse
//   O_RX_DATA         last received word, updated with O_DONE
//   O_SCLK, O_SS_N    SPI clock and active-low slave selects
//   O_MOSI, I_MISO    serial data out / in
module spi_master_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_SS     = 1,
    parameter int unsigned SS_SEL_W   = 1,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  I_CLK,
    input  logic                  I_RESETN,
    input  logic                  I_START,
    input  logic [DATA_WIDTH-1:0] I_TX_DATA,
    input  logic [SS_SEL_W-1:0]   I_SS_SEL,
    input  logic                  I_CPOL,
    input  logic                  I_CPHA,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic [DATA_WIDTH-1:0] O_RX_DATA,
    output logic                  O_SCLK,
    output logic [NUM_SS-1:0]     O_SS_N,
    output logic                  O_MOSI,
    input  logic                  I_MISO
);

    localparam int unsigned CNT_W   = $clog2(CLK_DIV + 1);
    localparam int unsigned HP_LAST = 2 * DATA_WIDTH;
    localparam int unsigned TOG_W   = $clog2(HP_LAST + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, LAG} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TOG_W-1:0]      tog_q, tog_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [SS_SEL_W-1:0]   sel_q, sel_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
    logic                  mosi_q, mosi_d;
    logic                  shift_out;
    logic                  sample_in;
    logic [NUM_SS-1:0]     ss_sel_n;

    // Decode the latched slave index; an out-of-range index selects nobody.
    always_comb begin
        ss_sel_n = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (sel_q == SS_SEL_W'(i)) begin
                ss_sel_n[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        sel_d     = sel_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_d      = rx_q;
        sclk_d    = sclk_q;
        ss_n_d    = ss_n_q;
        mosi_d    = mosi_q;
        shift_out = 1'b0;
        sample_in = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                ss_n_d = '1;
                sclk_d = cpol_q;
                if (I_START) begin
                    tx_d    = I_TX_DATA;
                    sel_d   = I_SS_SEL;
                    cpol_d  = I_CPOL;
                    cpha_d  = I_CPHA;
                    rx_sh_d = '0;
                    tog_d   = '0;
                    // One extra count so outputs appear one cycle after accept.
                    cnt_d   = CNT_W'(CLK_DIV);
                    state_d = LEAD;
                end
            end
            LEAD, XFER: begin
                busy_d = 1'b1;
                ss_n_d = ss_sel_n;
                if (state_q == LEAD) begin
                    sclk_d = cpol_q;
                    // CPHA=0 presents the first bit as soon as SS asserts.
                    if (cnt_q == CNT_W'(CLK_DIV) && !cpha_q) begin
                        shift_out = 1'b1;
                    end
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (tog_q == TOG_W'(HP_LAST)) begin
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = LAG;
                end else begin
                    // Start a new half-period: even tog_q means a leading edge.
                    state_d = XFER;
                    sclk_d  = ~sclk_q;
                    tog_d   = tog_q + TOG_W'(1);
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    if ((!tog_q[0]) != cpha_q) begin
                        sample_in = 1'b1;
                    end else if (tog_q != TOG_W'(HP_LAST - 1)) begin
                        shift_out = 1'b1;
                    end
                end
            end
            LAG: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ss_n_d  = '1;
                    rx_d    = rx_sh_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (shift_out) begin
            if (MSB_FIRST) begin
                mosi_d = tx_q[DATA_WIDTH-1];
                tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                mosi_d = tx_q[0];
                tx_d   = {1'b0, tx_q[DATA_WIDTH-1:1]};
            end
        end
        if (sample_in) begin
            if (MSB_FIRST) begin
                rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], I_MISO};
            end else begin
                rx_sh_d = {I_MISO, rx_sh_q[DATA_WIDTH-1:1]};
            end
        end
    end

    // State and output registers.
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            sel_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            ss_n_q  <= '1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            sel_q   <= sel_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
        end
    end

    assign O_BUSY    = busy_q;
    assign O_DONE    = done_q;
    assign O_RX_DATA = rx_q;
    assign O_SCLK    = sclk_q;
    assign O_SS_N    = ss_n_q;
    assign O_MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: randomized transfers, a slave model on MISO,
// a timing reference model and a scoreboard popped on O_DONE.
module tb_spi_master_engine;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int NSS  = 4;
    localparam int SSW  = 3;
    localparam int XLEN = (2 * W + 2) * D + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   tx = '0;
    logic [SSW-1:0] sel = '0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           busy, done, sclk, mosi, miso;
    logic [W-1:0]   rx;
    logic [NSS-1:0] ss_n;

    // Second build: LSB first, single slave, MISO looped back
    logic           l_start = 1'b0;
    logic [W-1:0]   l_tx = '0;
    logic           l_busy, l_done, l_sclk, l_mosi;
    logic [W-1:0]   l_rx;
    logic [0:0]     l_ss;
    logic [W-1:0]   l_wire = '0;

    always #5 clk = ~clk;

    spi_master_engine #(.DATA_WIDTH(W), .CLK_DIV(D), .NUM_SS(NSS), .SS_SEL_W(SSW), .MSB_FIRST(1'b1)) dut (
        .I_CLK(clk), .I_RESETN(rst_n), .I_START(start), .I_TX_DATA(tx), .I_SS_SEL(sel),
        .I_CPOL(cpol), .I_CPHA(cpha), .O_BUSY(busy), .O_DONE(done), .O_RX_DATA(rx),
        .O_SCLK(sclk), .O_SS_N(ss_n), .O_MOSI(mosi), .I_MISO(miso)
    );

    spi_master_engine #(.DATA_WIDTH(W), .CLK_DIV(2), .NUM_SS(1), .SS_SEL_W(1), .MSB_FIRST(1'b0)) dut_lsb (
        .I_CLK(clk), .I_RESETN(rst_n), .I_START(l_start), .I_TX_DATA(l_tx), .I_SS_SEL(1'b0),
        .I_CPOL(1'b0), .I_CPHA(1'b0), .O_BUSY(l_busy), .O_DONE(l_done), .O_RX_DATA(l_rx),
        .O_SCLK(l_sclk), .O_SS_N(l_ss), .O_MOSI(l_mosi), .I_MISO(l_mosi)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] exp_rx;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int           cyc = 0;
    int           acc_cyc = 0;
    int           next_free = 0;
    int           acc_cnt = 0;
    bit           act = 1'b0;
    logic         idle_cpol = 1'b0;
    logic         cur_cpol = 1'b0;
    logic         cur_cpha = 1'b0;
    int           cur_sel = 0;
    logic [W-1:0] cur_sw = '0;
    logic         cur_loop = 1'b0;
    logic [W-1:0] next_sw = '0;
    logic         next_loop = 1'b0;
    logic [W-1:0] model_rx = '0;

    // Slave model state
    logic         slave_miso = 1'b0;
    logic [W-1:0] slave_rcv = '0;
    bit           s_act = 1'b0;
    logic         s_prev = 1'b0;
    int           s_idx = 0;

    assign miso = cur_loop ? mosi : slave_miso;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, a, e, cyc);
        end
    endtask

    // Expected SCLK k cycles after accept: toggles every D cycles after the lead phase.
    function automatic logic exp_sclk(input int k, input logic cp);
        int n;
        if (k < 1 + D) n = 0;
        else begin
            n = (k - 1 - D) / D + 1;
            if (n > 2 * W) n = 2 * W;
        end
        return cp ^ n[0];
    endfunction

    // Acceptance model: a request is taken once the previous transfer's done cycle is reached.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            act = 1'b0;
            sb.delete();
            idle_cpol = 1'b0;
            next_free = 0;
        end else if (start && cyc >= next_free) begin
            if (act) idle_cpol = cur_cpol;
            act = 1'b1;
            acc_cyc = cyc;
            next_free = cyc + XLEN + 1;
            cur_cpol = cpol;
            cur_cpha = cpha;
            cur_sel = int'(sel);
            cur_sw = next_sw;
            cur_loop = next_loop;
            sb.push_back('{tx: tx, exp_rx: (next_loop ? tx : next_sw)});
            acc_cnt++;
        end
    end

    // SPI slave: drives cur_sw, captures MOSI, framed by O_BUSY.
    always @(negedge clk) begin
        if (!busy) begin
            s_act = 1'b0;
        end else if (!s_act) begin
            s_act = 1'b1;
            s_idx = 0;
            slave_rcv = '0;
            s_prev = sclk;
            if (!cur_cpha) begin
                slave_miso = cur_sw[W-1];
                s_idx = 1;
            end
        end else if (sclk != s_prev) begin
            s_prev = sclk;
            if ((sclk != cur_cpol) != cur_cpha) begin
                slave_rcv = {slave_rcv[W-2:0], mosi};
            end else begin
                if (s_idx < W) slave_miso = cur_sw[W-1-s_idx];
                s_idx++;
            end
        end
    end

    // Monitor: per-cycle timing checks plus scoreboard pop on O_DONE.
    always @(negedge clk) begin
        logic           e_busy, e_done, e_sclk;
        logic [NSS-1:0] e_ss;
        logic [NSS-1:0] one;
        int             k;
        exp_t           e;
        if (!rst_n) begin
            model_rx = '0;
        end else begin
            one = NSS'(1);
            k = cyc - acc_cyc;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_ss = '1;
            e_sclk = act ? cur_cpol : idle_cpol;
            if (act) begin
                if (k == 0) begin
                    e_sclk = idle_cpol;
                end else if (k < XLEN) begin
                    e_busy = 1'b1;
                    if (cur_sel < NSS) e_ss = ~(one << cur_sel);
                    e_sclk = exp_sclk(k, cur_cpol);
                end else if (k == XLEN) begin
                    e_done = 1'b1;
                end
            end
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("ss_n", 32'(ss_n), 32'(e_ss));
            check("sclk", 32'(sclk), 32'(e_sclk));
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_without_request", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    model_rx = e.exp_rx;
                    check("rx_data", 32'(rx), 32'(e.exp_rx));
                    check("slave_rcv", 32'(slave_rcv), 32'(e.tx));
                end
            end else begin
                check("rx_hold", 32'(rx), 32'(model_rx));
            end
        end
    end

    // Capture the LSB-first build's wire order on leading (rising) SCLK edges.
    always @(posedge l_sclk) begin
        if (l_busy) l_wire = {l_wire[W-2:0], l_mosi};
    end

    task automatic wait_accept();
        int n = acc_cnt;
        int i = 0;
        while (acc_cnt == n && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (acc_cnt == n) check("accept_timeout", 32'(acc_cnt), 32'(n + 1));
    endtask

    task automatic wait_idle();
        int i = 0;
        while (act && (cyc - acc_cyc) <= XLEN && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", 32'(act && (cyc - acc_cyc) <= XLEN), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic launch(input logic [W-1:0] t, input logic [W-1:0] s, input int sl,
                          input logic pol, input logic pha, input logic lp);
        @(negedge clk);
        tx = t;
        next_sw = s;
        sel = SSW'(sl);
        cpol = pol;
        cpha = pha;
        next_loop = lp;
        start = 1'b1;
        wait_accept();
        start = 1'b0;
        // Input changes during the transfer must not matter.
        tx = W'($urandom);
        cpol = 1'($urandom);
        cpha = 1'($urandom);
        sel = SSW'($urandom);
    endtask

    task automatic xfer(input logic [W-1:0] t, input logic [W-1:0] s, input int sl,
                        input logic pol, input logic pha, input logic lp);
        launch(t, s, sl, pol, pha, lp);
        wait_idle();
    endtask

    task automatic lsb_xfer(input logic [W-1:0] v);
        logic [W-1:0] rev;
        int i;
        bit seen;
        for (int b = 0; b < W; b++) rev[W-1-b] = v[b];
        l_wire = '0;
        @(negedge clk);
        l_tx = v;
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        @(negedge clk);
        check("lsb_ss_low", 32'(l_ss), 32'd0);
        i = 0;
        seen = 1'b0;
        while (!seen && i < 200) begin
            @(negedge clk);
            seen = l_done;
            i++;
        end
        check("lsb_done_seen", 32'(seen), 32'd1);
        check("lsb_rx", 32'(l_rx), 32'(v));
        check("lsb_wire_order", 32'(l_wire), 32'(rev));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rx", 32'(rx), 32'd0);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_ss_n", 32'(ss_n), 32'hF);
        check("reset_mosi", 32'(mosi), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mode 0 loopback, mode 3 against the slave model
        xfer(8'hA5, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        xfer(8'hC3, 8'h3C, 0, 1'b1, 1'b1, 1'b0);

        // Start pulsed mid-transfer is ignored
        launch(8'h69, 8'h96, 1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tx = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Slave select decode, including an out-of-range index
        xfer(8'h12, 8'h34, 2, 1'b0, 1'b1, 1'b0);
        xfer(8'h56, 8'h78, 5, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset around bit 3
        launch(8'h33, 8'hCC, 1, 1'b1, 1'b1, 1'b0);
        repeat (28) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ss_n", 32'(ss_n), 32'hF);
        check("midreset_sclk", 32'(sclk), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_rx", 32'(rx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(8'h5A, 8'hE1, 3, 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        tx = 8'hFF;
        next_sw = 8'h11;
        next_loop = 1'b0;
        sel = SSW'(0);
        cpol = 1'b0;
        cpha = 1'b0;
        start = 1'b1;
        wait_accept();
        tx = 8'hFE;
        next_sw = 8'h22;
        wait_accept();
        tx = 8'hFD;
        next_sw = 8'h33;
        wait_accept();
        start = 1'b0;
        wait_idle();

        // Randomized transfers
        for (int n = 0; n < 25; n++) begin
            xfer(W'($urandom), W'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // LSB-first build
        lsb_xfer(8'h01);
        lsb_xfer(8'h5A);
        lsb_xfer(W'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
Native, parametrised SPI master engine that replaces the vendor SPI IP core and its register-programming control sequencer. It takes a single start/data handshake from user logic and generates SCLK, MOSI and per-slave SS_N directly. Data width, clock divider, bit order and slave count are parameters; CPOL/CPHA mode is selectable per transfer. It sits between the button/data management logic of the board top and the SPI pins.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 4, I_CLK cycles per SCLK half-period (>=1)
NUM_SS, 1, number of slave-select lines (>=1)
SS_SEL_W, 1, width of I_SS_SEL; must satisfy 2**SS_SEL_W >= NUM_SS
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
I_CLK  in  1  system clock
I_RESETN  in  1  asynchronous active-low reset
I_START  in  1  transfer request, sampled in IDLE only
I_TX_DATA  in  DATA_WIDTH  word to transmit, latched on accept
I_SS_SEL  in  SS_SEL_W  target slave index, latched on accept
I_CPOL  in  1  SCLK idle level, latched on accept
I_CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge
O_BUSY  out  1  high from the cycle after accept until the done cycle
O_DONE  out  1  one-cycle pulse at end of transfer
O_RX_DATA  out  DATA_WIDTH  last received word, valid from O_DONE, held until next O_DONE
O_SCLK  out  1  SPI clock
O_SS_N  out  NUM_SS  active-low slave selects
O_MOSI  out  1  serial data out
I_MISO  in  1  serial data in

Behaviour:
- All outputs registered. Reset values: O_BUSY=0, O_DONE=0, O_RX_DATA=0, O_SCLK=0, O_SS_N=all 1, O_MOSI=0, internal CPOL=0.
- FSM: IDLE -> LEAD -> XFER -> LAG -> IDLE. One shared down-counter times half-periods (CLK_DIV cycles each).
- IDLE: O_SCLK = latched CPOL. I_START=1 is accepted at the clock edge, which is edge 0. At that edge: latch TX, SS_SEL, CPOL, CPHA; go to LEAD. From edge 1: O_BUSY=1 and the selected O_SS_N bit is 0.
- LEAD: lasts CLK_DIV cycles. When CPHA=0, the first data bit is on O_MOSI from edge 1.
- XFER: 2*DATA_WIDTH half-periods. O_SCLK toggles at the start of each half-period; the first toggle is the leading edge.
  - CPHA=0: sample I_MISO on each leading edge; shift the next bit out on each trailing edge. There is no shift after the final trailing edge.
  - CPHA=1: shift a bit out on each leading edge; sample on each trailing edge.
  - After the final half-period, O_SCLK is back at CPOL.
- LAG: CLK_DIV cycles with SS still asserted, then go to IDLE.
- Done timing: at edge (2*DATA_WIDTH+2)*CLK_DIV + 1, O_SS_N returns to all 1, O_BUSY=0, O_DONE=1 for exactly one cycle, and O_RX_DATA updates.
- The O_DONE cycle is IDLE, so I_START held high there is accepted (back-to-back transfers).
- Bit order follows MSB_FIRST for both TX and RX.
- I_START while busy is ignored. There is no queueing and the latched data is unaffected.
- I_SS_SEL >= NUM_SS: the transfer runs with normal timing and O_DONE, but all O_SS_N stay high.
- Changes to I_CPOL/I_CPHA/I_TX_DATA while busy have no effect on the current transfer.
- Asynchronous reset mid-transfer: all outputs go immediately to reset values, the FSM returns to IDLE, and no O_DONE is produced.
- O_MOSI holds its last bit while in IDLE.

Test Plan:
- DATA_WIDTH=8, CLK_DIV=4, mode 0, I_MISO looped to O_MOSI, TX=0xA5 -> O_RX_DATA=0xA5; O_DONE exactly 73 cycles after accept; 8 rising SCLK edges; SS_N low for 72 cycles.
- Mode 3, slave model drives 0x3C on MISO (shifting on falling edge), TX=0xC3 -> O_SCLK idles 1; slave receives 0xC3; O_RX_DATA=0x3C.
- I_START pulsed mid-transfer with TX=0xFF -> ignored; exactly one O_DONE; O_RX_DATA from the original word only.
- NUM_SS=4, SS_SEL=2 -> only O_SS_N[2] goes low. SS_SEL=5 (SS_SEL_W=3) -> all SS_N stay high, O_DONE still pulses at the normal cycle.
- I_RESETN low at bit 3 of a transfer -> O_SS_N=all 1, O_SCLK=0, O_BUSY=0 asynchronously; no O_DONE; next transfer 0x5A completes correctly.
- I_START held high, TX counting down 0xFF, 0xFE, 0xFD -> three consecutive transfers, each accepted in the O_DONE cycle of the previous one, with no idle gap; MSB_FIRST=0 build reverses bit order on the wire.
